// File: rtl/btb_predict_param.sv
// btb_predict_param
//   Parametrised dual-port direct-mapped branch target buffer with in-place
//   2-bit saturating counters, allocate-on-taken-miss, and a post-reset sweep
//   that clears every valid bit before lookups and updates go live.
//
// Ports
//   CLK                       clock, all state changes on posedge
//   RST                       synchronous active-high reset, restarts the sweep
//   ready                     1 = sweep done, lookups/updates live
//   pc1, pc2                  lookup PCs (word address) for fetch slots 1/2
//   hit_predict1/2            registered: valid & tag match & cnt >= 2
//   state1/2                  registered: counter of the indexed entry
//   pre_pc1/2                 registered: target of the indexed entry
//   upd_en                    resolved-branch update strobe (ignored while !ready)
//   upd_pc, upd_taken,
//   upd_target                resolved branch PC, direction and target
//
// Build option
//   BTB_PREDICT_BYPASS_EN     when defined, a lookup that indexes the entry
//                             being written in the same cycle sees the
//                             post-update entry; otherwise it sees the old one.
//
// FSM states
//   state   | meaning
//   ST_INIT | sweeping: clear valid[ptr] each cycle, outputs held at 0
//   ST_RUN  | ready: lookups registered, updates accepted

module btb_predict_param #(
  parameter int PC_W  = 13,
  parameter int IDX_W = 11,
  parameter int TGT_W = 13
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             ready,
  input  logic [PC_W-1:0]  pc1,
  input  logic [PC_W-1:0]  pc2,
  output logic             hit_predict1,
  output logic             hit_predict2,
  output logic [1:0]       state1,
  output logic [1:0]       state2,
  output logic [TGT_W-1:0] pre_pc1,
  output logic [TGT_W-1:0] pre_pc2,
  input  logic             upd_en,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [TGT_W-1:0] upd_target
);

  localparam int TAG_W = PC_W - IDX_W;
  localparam int DEPTH = 1 << IDX_W;

  generate
    if (TAG_W < 1) begin : g_bad_tag
      $error("btb_predict_param: PC_W must exceed IDX_W");
    end
  endgenerate

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               sweep_clr;

  // Only valid bits are cleared; counters, tags and targets keep whatever
  // they held, which is harmless because nothing reads them as a hit.
  logic [DEPTH-1:0]   valid_q;
  logic [1:0]         cnt_mem [DEPTH];
  logic [TAG_W-1:0]   tag_mem [DEPTH];
  logic [TGT_W-1:0]   tgt_mem [DEPTH];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sweep_clr = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_clr = 1'b1;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == {IDX_W{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign ready = (state_q == ST_RUN);

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_acc;
  logic             u_hit;
  logic             u_wr;
  logic             u_we;
  logic             new_valid;
  logic [1:0]       new_cnt;
  logic [TAG_W-1:0] new_tag;
  logic [TGT_W-1:0] new_tgt;

  assign u_idx = upd_pc[IDX_W-1:0];
  assign u_tag = upd_pc[PC_W-1:IDX_W];
  // An update coinciding with RST is dropped even though ready may still be 1.
  assign u_acc = upd_en & ready & ~RST;
  assign u_hit = valid_q[u_idx] & (tag_mem[u_idx] == u_tag);

  always_comb begin
    new_valid = valid_q[u_idx];
    new_cnt   = cnt_mem[u_idx];
    new_tag   = tag_mem[u_idx];
    new_tgt   = tgt_mem[u_idx];
    u_wr      = 1'b0;
    if (u_hit) begin
      u_wr = 1'b1;
      if (upd_taken) begin
        new_cnt = (cnt_mem[u_idx] == 2'b11) ? 2'b11 : cnt_mem[u_idx] + 2'd1;
        new_tgt = upd_target;
      end else begin
        new_cnt = (cnt_mem[u_idx] == 2'b00) ? 2'b00 : cnt_mem[u_idx] - 2'd1;
      end
    end else if (upd_taken) begin
      u_wr      = 1'b1;
      new_valid = 1'b1;
      new_tag   = u_tag;
      new_tgt   = upd_target;
      new_cnt   = 2'b10;
    end
  end

  assign u_we = u_acc & u_wr;

  // Sweep and update never overlap: one needs ST_INIT, the other ST_RUN.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (sweep_clr) begin
        valid_q[ptr_q] <= 1'b0;
      end else if (u_we) begin
        valid_q[u_idx] <= new_valid;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (u_we) begin
      cnt_mem[u_idx] <= new_cnt;
      tag_mem[u_idx] <= new_tag;
      tgt_mem[u_idx] <= new_tgt;
    end
  end

  // ---------------------------------------------------------------- lookup
  logic [PC_W-1:0]  lk_pc    [2];
  logic [IDX_W-1:0] lk_idx   [2];
  logic             lk_valid [2];
  logic [1:0]       lk_cnt   [2];
  logic [TAG_W-1:0] lk_tag   [2];
  logic [TGT_W-1:0] lk_tgt   [2];
  logic             lk_hit   [2];

  assign lk_pc[0] = pc1;
  assign lk_pc[1] = pc2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lk_idx[p]   = lk_pc[p][IDX_W-1:0];
      lk_valid[p] = valid_q[lk_idx[p]];
      lk_cnt[p]   = cnt_mem[lk_idx[p]];
      lk_tag[p]   = tag_mem[lk_idx[p]];
      lk_tgt[p]   = tgt_mem[lk_idx[p]];
`ifdef BTB_PREDICT_BYPASS_EN
      if (u_we && (lk_idx[p] == u_idx)) begin
        lk_valid[p] = new_valid;
        lk_cnt[p]   = new_cnt;
        lk_tag[p]   = new_tag;
        lk_tgt[p]   = new_tgt;
      end
`endif
      lk_hit[p] = lk_valid[p] & (lk_tag[p] == lk_pc[p][PC_W-1:IDX_W]) & lk_cnt[p][1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || (state_q != ST_RUN)) begin
      hit_predict1 <= 1'b0;
      hit_predict2 <= 1'b0;
      state1       <= '0;
      state2       <= '0;
      pre_pc1      <= '0;
      pre_pc2      <= '0;
    end else begin
      hit_predict1 <= lk_hit[0];
      hit_predict2 <= lk_hit[1];
      state1       <= lk_cnt[0];
      state2       <= lk_cnt[1];
      pre_pc1      <= lk_tgt[0];
      pre_pc2      <= lk_tgt[1];
    end
  end

endmodule

// File: tb/tb_btb_predict_param.sv
module tb_btb_predict_param;

  logic        CLK;
  logic        RST;
  logic        ready;
  logic [12:0] pc1, pc2;
  logic        hit_predict1, hit_predict2;
  logic [1:0]  state1, state2;
  logic [12:0] pre_pc1, pre_pc2;
  logic        upd_en;
  logic [12:0] upd_pc;
  logic        upd_taken;
  logic [12:0] upd_target;

  int checks = 0;
  int errors = 0;

`ifdef BTB_PREDICT_BYPASS_EN
  localparam logic [1:0] COL_ST = 2'd3;
`else
  localparam logic [1:0] COL_ST = 2'd2;
`endif

  btb_predict_param #(.PC_W(13), .IDX_W(11), .TGT_W(13)) dut (
    .CLK(CLK), .RST(RST), .ready(ready),
    .pc1(pc1), .pc2(pc2),
    .hit_predict1(hit_predict1), .hit_predict2(hit_predict2),
    .state1(state1), .state2(state2),
    .pre_pc1(pre_pc1), .pre_pc2(pre_pc2),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ck: 0 = skip port, 1 = hit only, 2 = hit/state/target
  typedef struct {
    logic        ue;
    logic [12:0] upc;
    logic        ut;
    logic [12:0] utg;
    logic [12:0] p1, p2;
    int          ck1, ck2;
    logic        h1;
    logic [1:0]  s1;
    logic [12:0] t1;
    logic        h2;
    logic [1:0]  s2;
    logic [12:0] t2;
  } vec_t;

  function automatic vec_t mk(input logic ue, input logic [12:0] upc, input logic ut,
                              input logic [12:0] utg, input logic [12:0] p1,
                              input logic [12:0] p2, input int ck1, input int ck2,
                              input logic h1, input logic [1:0] s1, input logic [12:0] t1,
                              input logic h2, input logic [1:0] s2, input logic [12:0] t2);
    vec_t v;
    v.ue = ue; v.upc = upc; v.ut = ut; v.utg = utg; v.p1 = p1; v.p2 = p2;
    v.ck1 = ck1; v.ck2 = ck2; v.h1 = h1; v.s1 = s1; v.t1 = t1;
    v.h2 = h2; v.s2 = s2; v.t2 = t2;
    return v;
  endfunction

  task automatic chk_port(input string tag, input int ck,
                          input logic h, input logic [1:0] s, input logic [12:0] t,
                          input logic eh, input logic [1:0] es, input logic [12:0] et);
    if (ck >= 1) chk({tag, "_hit"}, 32'(h), 32'(eh));
    if (ck >= 2) begin
      chk({tag, "_state"}, 32'(s), 32'(es));
      chk({tag, "_target"}, 32'(t), 32'(et));
    end
  endtask

  // Reset, optionally re-assert RST after restart_at cycles, then measure
  // the number of cycles until ready rises counted from the final RST edge.
  task automatic run_sweep(input int restart_at, input bit inject_upd);
    int n;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_hit1", 32'(hit_predict1), 0);
    chk("rst_state2", 32'(state2), 0);
    n = 0;
    while (ready !== 1'b1 && n < 4000) begin
      if (inject_upd && n == 500) begin
        upd_en = 1'b1; upd_pc = 13'h020; upd_taken = 1'b1; upd_target = 13'h111;
      end
      @(posedge CLK); #1;
      upd_en = 1'b0;
      n++;
      if (n == restart_at) begin
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        n = 0;
        restart_at = -1;
      end
      if (n == 700) begin
        chk("sweep_out", {16'(hit_predict1), 8'(state1), 8'(pre_pc1[7:0])}, 0);
        chk("sweep_out2", {19'(hit_predict2), state2, 13'(pre_pc2)} & 32'h7fff, 0);
      end
    end
    chk("sweep_len", n, 2048);
  endtask

  vec_t v[20];

  initial begin
    RST = 1'b1; pc1 = '0; pc2 = '0;
    upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;

    v[0]  = mk(1, 13'h005, 1, 13'h123, 13'h010, 13'h010, 1, 1, 0, 0, 0,        0, 0, 0);
    v[1]  = mk(0, 13'h000, 0, 13'h000, 13'h005, 13'h805, 2, 2, 1, 2, 13'h123,  0, 2, 13'h123);
    v[2]  = mk(1, 13'h005, 1, 13'h123, 13'h005, 13'h010, 2, 1, 1, COL_ST, 13'h123, 0, 0, 0);
    v[3]  = mk(1, 13'h005, 1, 13'h123, 13'h010, 13'h010, 1, 1, 0, 0, 0,        0, 0, 0);
    v[4]  = mk(1, 13'h005, 1, 13'h123, 13'h010, 13'h010, 1, 1, 0, 0, 0,        0, 0, 0);
    v[5]  = mk(0, 13'h000, 0, 13'h000, 13'h005, 13'h005, 2, 2, 1, 3, 13'h123,  1, 3, 13'h123);
    v[6]  = mk(1, 13'h005, 0, 13'h777, 13'h010, 13'h010, 1, 1, 0, 0, 0,        0, 0, 0);
    v[7]  = mk(0, 13'h000, 0, 13'h000, 13'h005, 13'h005, 2, 2, 1, 2, 13'h123,  1, 2, 13'h123);
    v[8]  = mk(1, 13'h005, 0, 13'h777, 13'h010, 13'h010, 0, 0, 0, 0, 0,        0, 0, 0);
    v[9]  = mk(0, 13'h000, 0, 13'h000, 13'h005, 13'h010, 2, 0, 0, 1, 13'h123,  0, 0, 0);
    v[10] = mk(1, 13'h005, 0, 13'h777, 13'h010, 13'h010, 0, 0, 0, 0, 0,        0, 0, 0);
    v[11] = mk(0, 13'h000, 0, 13'h000, 13'h005, 13'h010, 2, 0, 0, 0, 13'h123,  0, 0, 0);
    v[12] = mk(1, 13'h005, 0, 13'h777, 13'h010, 13'h010, 0, 0, 0, 0, 0,        0, 0, 0);
    v[13] = mk(0, 13'h000, 0, 13'h000, 13'h005, 13'h010, 2, 0, 0, 0, 13'h123,  0, 0, 0);
    v[14] = mk(1, 13'h010, 0, 13'h055, 13'h010, 13'h010, 1, 1, 0, 0, 0,        0, 0, 0);
    v[15] = mk(0, 13'h000, 0, 13'h000, 13'h010, 13'h010, 1, 1, 0, 0, 0,        0, 0, 0);
    v[16] = mk(1, 13'h805, 1, 13'h400, 13'h010, 13'h020, 1, 1, 0, 0, 0,        0, 0, 0);
    v[17] = mk(0, 13'h000, 0, 13'h000, 13'h005, 13'h805, 2, 2, 0, 2, 13'h400,  1, 2, 13'h400);
    v[18] = mk(0, 13'h000, 0, 13'h000, 13'h805, 13'h805, 2, 2, 1, 2, 13'h400,  1, 2, 13'h400);
    v[19] = mk(0, 13'h000, 0, 13'h000, 13'h020, 13'h010, 1, 1, 0, 0, 0,        0, 0, 0);

    repeat (2) @(posedge CLK);
    #1;
    pc1 = 13'h805; pc2 = 13'h005;
    run_sweep(-1, 1'b1);

    for (int i = 0; i < 20; i++) begin
      upd_en = v[i].ue; upd_pc = v[i].upc; upd_taken = v[i].ut; upd_target = v[i].utg;
      pc1 = v[i].p1; pc2 = v[i].p2;
      @(posedge CLK); #1;
      chk_port($sformatf("v%0d_p1", i), v[i].ck1, hit_predict1, state1, pre_pc1,
               v[i].h1, v[i].s1, v[i].t1);
      chk_port($sformatf("v%0d_p2", i), v[i].ck2, hit_predict2, state2, pre_pc2,
               v[i].h2, v[i].s2, v[i].t2);
    end
    upd_en = 1'b0;

    // Reset from RUN with an update in the RST cycle, plus a second RST
    // mid-sweep; the entry at idx 5 must come back invalid but keep cnt/target.
    pc1 = 13'h805; pc2 = 13'h005;
    upd_en = 1'b1; upd_pc = 13'h805; upd_taken = 1'b1; upd_target = 13'h0aa;
    RST = 1'b1;
    @(posedge CLK); #1;
    upd_en = 1'b0;
    run_sweep(1000, 1'b0);

    pc1 = 13'h805; pc2 = 13'h005;
    @(posedge CLK); #1;
    chk("post_rst_ready", 32'(ready), 1);
    chk_port("post_rst_p1", 2, hit_predict1, state1, pre_pc1, 1'b0, 2'd2, 13'h400);
    chk_port("post_rst_p2", 2, hit_predict2, state2, pre_pc2, 1'b0, 2'd2, 13'h400);

    // Fresh allocate after the sweep works again.
    upd_en = 1'b1; upd_pc = 13'h005; upd_taken = 1'b1; upd_target = 13'h0bb;
    @(posedge CLK); #1;
    upd_en = 1'b0; pc1 = 13'h005; pc2 = 13'h805;
    @(posedge CLK); #1;
    chk_port("realloc_p1", 2, hit_predict1, state1, pre_pc1, 1'b1, 2'd2, 13'h0bb);
    chk_port("realloc_p2", 1, hit_predict2, state2, pre_pc2, 1'b0, 2'd0, 13'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_predict_param.md
Name: btb_predict_param

Overview:
- Parametrised successor of the dual-port direct-mapped branch predictor.
- Two lookup ports are read every cycle and return hit, 2-bit counter state and predicted target one cycle later.
- Unlike the previous generation, the block updates its own counters (saturating inc/dec), allocates entries on taken misses, and clears all valid bits with a post-reset sweep FSM.
- Sits between fetch (lookups for the slot-1/slot-2 PCs) and the E stage (update with resolved outcome).

Parameters:
- PC_W, 13, word-address PC width (byte PC with the low 2 bits dropped).
- IDX_W, 11, index width; table depth = 2**IDX_W; tag width TAG_W = PC_W-IDX_W (localparam, must be >=1).
- TGT_W, 13, stored target width.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  synchronous, active-high reset.
- ready  out  1  1 = sweep done, lookups/updates live.
- pc1  in  PC_W  lookup PC, slot 1.
- pc2  in  PC_W  lookup PC, slot 2.
- hit_predict1  out  1  slot-1 predict taken.
- hit_predict2  out  1  slot-2 predict taken.
- state1  out  2  slot-1 counter of indexed entry.
- state2  out  2  slot-2 counter of indexed entry.
- pre_pc1  out  TGT_W  slot-1 predicted target.
- pre_pc2  out  TGT_W  slot-2 predicted target.
- upd_en  in  1  resolved branch update strobe.
- upd_pc  in  PC_W  PC of resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  TGT_W  actual target.

Behaviour:
- Entry fields: valid(1), cnt(2), tag(TAG_W), target(TGT_W). idx = pc[IDX_W-1:0]; tag = pc[PC_W-1:IDX_W].
- Lookup: pcN sampled at posedge k; outputs registered and valid from posedge k through k+1.
  - hit_predictN = valid & (tag match) & (cnt >= 2'b10).
  - stateN = cnt of the indexed entry. pre_pcN = its target. Both are reported regardless of hit.
- Both ports may use the same index; both return identical data.
- Update, applied at the posedge where upd_en=1 and ready=1:
  - Tag hit (valid & match): taken → cnt = min(cnt+1, 3) and target overwritten; not taken → cnt = max(cnt-1, 0), target kept.
  - Miss, taken: allocate/replace with valid=1, tag, target=upd_target, cnt=2'b10.
  - Miss, not taken: no change.
- Read/write collision: same-cycle lookup of the index being updated returns pre-update contents (unless BYPASS_EN).
- FSM states INIT and RUN.
  - RST=1 at any posedge → INIT, sweep ptr=0, ready=0, all lookup outputs 0.
  - INIT: each cycle valid[ptr]=0, ptr++. When ptr==2**IDX_W-1 is cleared → RUN; ready=1 from the next cycle.
  - Sweep length is exactly 2**IDX_W cycles after RST deasserts.
- In INIT: upd_en is ignored and lookup outputs are held at 0.
- RST asserted mid-sweep or mid-RUN restarts the sweep from 0; an update presented in the same cycle as RST is dropped.
- cnt/tag/target are not reset; only the valid bits are cleared.

Optional Feature:
- Macro: BTB_PREDICT_BYPASS_EN.
- Defined: when upd_en (accepted) and a lookup hit the same index in the same cycle, that lookup's registered outputs reflect the post-update entry (forwarded new cnt/tag/target/valid). Ports 1 and 2 are forwarded independently.
- Undefined: the lookup returns the pre-update entry.

Test Plan:
- Reset sweep: RST=1 for 1 cycle, then 0 → ready=0 for exactly 2048 cycles, then 1; lookup of any pc during the sweep → hit_predict=0, state=0, pre_pc=0.
- Allocate+predict: upd_pc=0x0005, taken=1, target=0x0123 → next-cycle lookup pc1=0x0005 gives hit_predict1=1, state1=2, pre_pc1=0x0123.
- Saturation: three more taken updates on 0x0005 → state1=3. Four not-taken updates → state 3→2→1→0→0; hit_predict1=0 once state<2; target stays 0x0123.
- Alias/tag: after the allocate, lookup pc2=0x0805 (same idx, tag 1) → hit_predict2=0, state2=2. Taken update on 0x0805 with target 0x0400 → replaces entry; 0x0005 now misses.
- Not-taken miss: upd_pc=0x0010, taken=0 on an empty entry → lookup 0x0010 still hit=0, valid unchanged.
- Collision: update 0x0005 taken (cnt 2→3) with pc1=0x0005 in the same cycle → state1=2 without BTB_PREDICT_BYPASS_EN, state1=3 with it. Same test with RST asserted mid-sweep (cycle 1000) → ready rises 2048 cycles after the final RST.
